// File: rtl/cross_bar_rr.sv
// cross_bar_rr: N_MST x N_SLV crossbar, one round-robin arbiter per slave port.
// Latency: grant registers s_* on the sampling edge; m_done pulses the cycle after s_ack; decode error pulses two cycles after sampling.
// Backpressure: masters hold m_req/command until m_done; s_req/s_* are held stable until s_ack.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m_req/m_we/m_addr/m_wdata  per-master command (flattened, master i at [i*W +: W])
//   m_done/m_err/m_rdata       per-master completion pulse, decode error flag, read data
//   s_req/s_we/s_addr/s_wdata  per-slave registered command
//   s_ack/s_rdata              per-slave single-cycle completion and read data
module cross_bar_rr #(
  parameter int N_MST = 2,
  parameter int N_SLV = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SW    = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_MST-1:0]    m_req,
  input  logic [N_MST-1:0]    m_we,
  input  logic [N_MST*AW-1:0] m_addr,
  input  logic [N_MST*DW-1:0] m_wdata,
  output logic [N_MST-1:0]    m_done,
  output logic [N_MST-1:0]    m_err,
  output logic [N_MST*DW-1:0] m_rdata,
  output logic [N_SLV-1:0]    s_req,
  output logic [N_SLV-1:0]    s_we,
  output logic [N_SLV*AW-1:0] s_addr,
  output logic [N_SLV*DW-1:0] s_wdata,
  input  logic [N_SLV-1:0]    s_ack,
  input  logic [N_SLV*DW-1:0] s_rdata
);

  localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Per-slave arbiter state
  logic [1:0]    state   [N_SLV];
  logic [MW-1:0] own     [N_SLV];
  logic [MW-1:0] last    [N_SLV];

  // Decode-error path: one cycle of pending before the error completion
  logic [N_MST-1:0] err_pend;
  logic [N_MST-1:0] err_start;

  // Decode results
  logic [SW-1:0]    sel     [N_MST];
  logic [N_MST-1:0] sel_ok;

  // Masters that must not be considered this cycle
  logic [N_MST-1:0] owned;
  logic [N_MST-1:0] blocked;

  // Arbitration results
  logic [N_SLV-1:0] gnt_vld;
  logic [MW-1:0]    gnt_idx [N_SLV];

  // Slave select comes from the top SW address bits; anything at or beyond
  // N_SLV has no slave behind it.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      sel[i]    = m_addr[i*AW + AW - SW +: SW];
      sel_ok[i] = (int'(sel[i]) < N_SLV);
    end
  end

  // A master is owned while any slave is BUSY or DONE on its behalf.
  always_comb begin
    owned = '0;
    for (int j = 0; j < N_SLV; j++) begin
      for (int i = 0; i < N_MST; i++) begin
        if (state[j] != ST_IDLE && own[j] == MW'(i)) begin
          owned[i] = 1'b1;
        end
      end
    end
  end

  // The done-holdoff cycle (m_done high) and a pending decode error also
  // exclude the master: its request lines still show the finished command.
  assign blocked = owned | m_done | err_pend;

  // Round-robin arbitration. Slaves are scanned in index order and each
  // winner is marked taken before the next slave looks, so a master can
  // never be granted by two slaves in the same cycle.
  always_comb begin
    logic [N_MST-1:0] taken;
    logic [MW-1:0]    cidx;
    logic             found;
    logic [MW-1:0]    widx;
    int               c;
    taken = blocked;
    cidx  = '0;
    c     = 0;
    for (int j = 0; j < N_SLV; j++) begin
      found = 1'b0;
      widx  = '0;
      if (state[j] == ST_IDLE) begin
        for (int k = 1; k <= N_MST; k++) begin
          c = int'(last[j]) + k;
          if (c >= N_MST) begin
            c = c - N_MST;
          end
          cidx = MW'(c);
          if (!found && m_req[cidx] && sel_ok[cidx] &&
              sel[cidx] == SW'(j) && !taken[cidx]) begin
            found = 1'b1;
            widx  = cidx;
          end
        end
      end
      if (found) begin
        taken[widx] = 1'b1;
      end
      gnt_vld[j] = found;
      gnt_idx[j] = widx;
    end
  end

  // Decode errors are accepted under the same exclusion rules as grants.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      err_start[i] = m_req[i] & ~sel_ok[i] & ~blocked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_done   <= '0;
      m_err    <= '0;
      m_rdata  <= '0;
      s_req    <= '0;
      s_we     <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      err_pend <= '0;
      for (int j = 0; j < N_SLV; j++) begin
        state[j] <= ST_IDLE;
        own[j]   <= '0;
        last[j]  <= MW'(N_MST - 1);
      end
    end else begin
      // Completion flags are single-cycle pulses; m_rdata holds.
      m_done <= '0;
      m_err  <= '0;

      for (int i = 0; i < N_MST; i++) begin
        if (err_pend[i]) begin
          err_pend[i]          <= 1'b0;
          m_done[i]            <= 1'b1;
          m_err[i]             <= 1'b1;
          m_rdata[i*DW +: DW]  <= '0;
        end else if (err_start[i]) begin
          err_pend[i] <= 1'b1;
        end
      end

      for (int j = 0; j < N_SLV; j++) begin
        case (state[j])
          ST_IDLE: begin
            // s_ack arriving here (late or spurious) is ignored.
            if (gnt_vld[j]) begin
              own[j]              <= gnt_idx[j];
              last[j]             <= gnt_idx[j];
              s_req[j]            <= 1'b1;
              s_we[j]             <= m_we[gnt_idx[j]];
              s_addr[j*AW +: AW]  <= m_addr[int'(gnt_idx[j])*AW +: AW];
              s_wdata[j*DW +: DW] <= m_wdata[int'(gnt_idx[j])*DW +: DW];
              state[j]            <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (s_ack[j]) begin
              s_req[j]     <= 1'b0;
              m_done[own[j]] <= 1'b1;
              m_rdata[int'(own[j])*DW +: DW] <= s_we[j] ? '0 : s_rdata[j*DW +: DW];
              state[j]     <= ST_DONE;
            end
          end
          ST_DONE: begin
            // One quiet cycle so the master can retire its command before
            // this slave samples requests again.
            state[j] <= ST_IDLE;
          end
          default: begin
            state[j] <= ST_IDLE;
            s_req[j] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cross_bar_rr.md
Name: cross_bar_rr

Overview:
- Parametrised N-master x M-slave crossbar.
- Each slave port has its own round-robin arbiter, so transfers to different slaves run concurrently.
- Masters issue single read/write transfers with a req/done handshake. Slave select is decoded from the top address bits.
- Sits between master agents and slave models; supersedes the fixed 2x2 crossbar with its state-based mux toggling.

Parameters:
- N_MST, 2, number of master ports (2..8)
- N_SLV, 2, number of slave ports (1..8)
- AW, 32, address width
- DW, 32, data width
- SW, $clog2(N_SLV) (min 1), slave-select bits taken from addr[AW-1 -: SW]

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_req  in  N_MST  per-master transfer request; held with command until m_done
- m_we  in  N_MST  1=write, 0=read
- m_addr  in  N_MST*AW  master address, flattened, master i at [i*AW +: AW]
- m_wdata  in  N_MST*DW  write data, flattened
- m_done  out  N_MST  one-cycle completion pulse
- m_err  out  N_MST  valid with m_done; decode error
- m_rdata  out  N_MST*DW  read data, valid with m_done
- s_req  out  N_SLV  slave request; held until s_ack
- s_we  out  N_SLV  registered write enable
- s_addr  out  N_SLV*AW  registered address
- s_wdata  out  N_SLV*DW  registered write data
- s_ack  in  N_SLV  slave completion, single cycle
- s_rdata  in  N_SLV*DW  slave read data, valid with s_ack

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values (rst_n=0 at posedge):
  - m_done, m_err, m_rdata, s_req, s_we, s_addr, s_wdata = 0.
  - Every arbiter is in IDLE.
  - Every round-robin pointer last[j] = N_MST-1, so master 0 has first priority.
- Decode: sel_i = m_addr_i[AW-1 -: SW]. If sel_i >= N_SLV, the request is a decode error.
- Per-slave FSM j, states IDLE, BUSY, DONE:
  - IDLE: candidates are masters with m_req=1, sel=j, not already owned by another slave, and not in the done-holdoff cycle.
    - Winner = first candidate scanning last[j]+1, last[j]+2, ... mod N_MST.
    - At the posedge: latch winner into own[j]; last[j] <= winner; copy we/addr/wdata into s_*; s_req[j] <= 1; go BUSY.
    - No candidate: stay IDLE.
  - BUSY: s_req and s_* are held stable.
    - On s_ack[j]=1 at a posedge: s_req[j] <= 0; m_done[own] <= 1; m_rdata[own] <= s_rdata[j] for reads, 0 for writes; go DONE.
  - DONE: one cycle, then IDLE. m_done is pulsed only in this cycle.
- Master obligations:
  - The master drops m_req (or presents a new command) on the posedge after it sees m_done.
  - The arbiter does not sample m_req during DONE.
  - Master i is excluded from every arbiter during the cycle its m_done is high.
- Latency:
  - m_req sampled at edge 0 with the slave IDLE -> s_req high after edge 0.
  - s_ack at edge k -> m_done high for the cycle after edge k.
  - Next arbitration for that slave at edge k+2.
  - Minimum turnaround is 3 cycles with a zero-wait slave.
- Concurrency:
  - Different slaves serve different masters in the same cycles.
  - A master owns at most one slave.
  - Arbiters are evaluated in index order j=0..N_SLV-1 within a cycle, so one master can never be granted twice.
- Decode error:
  - A request with sel >= N_SLV gets m_done=1 and m_err=1 two cycles after it is sampled, with m_rdata=0.
  - No slave port is touched.
- m_rdata holds its last value between m_done pulses.
- Fairness: with all masters requesting one slave continuously, grants rotate 0,1,..,N_MST-1,0,...
- Reset mid-operation:
  - Any BUSY/DONE transfer is abandoned and s_req drops at that edge.
  - No m_done is issued for the abandoned transfer.
  - A late s_ack after reset is ignored in IDLE.
- s_ack in IDLE or DONE is ignored.
- Unused high address bits are passed through unchanged.

Test Plan:
- Reset release, N_MST=2, N_SLV=2: master0 reads addr 0x0000_0010 and slave0 acks after 2 cycles with rdata 0xA5A5_0001 -> s_req[0] high for 3 cycles, m_done[0] pulses one cycle with m_rdata 0xA5A5_0001, m_err=0.
- Parallel transfers: master0 writes 0x0000_0004 and master1 writes 0x8000_0004 in the same cycle -> s_req[0] and s_req[1] rise together, each s_wdata matches its master, both m_done pulse together with zero-wait slaves.
- Contention: both masters hold requests to slave1 (0x8000_0000) for 4 transfers with zero-wait acks -> grant order 0,1,0,1, done pulses every 3 cycles.
- Decode error: N_SLV=3, master1 addr 0xC000_0000 (sel=3) -> m_done[1] and m_err[1] after 2 cycles, all s_req stay 0.
- Mid-transfer reset: rst_n=0 while slave0 is BUSY, then s_ack one cycle after reset release -> s_req[0]=0, no m_done, arbiter IDLE.
- Scaled config N_MST=4, N_SLV=4: all four masters request slave2 -> grants in order 0,1,2,3, and each completion's m_rdata is routed only to its owner.
